// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter placing NUM_PORTS requesters onto one
// SDRAM core command port, with one transaction outstanding at a time.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_rd[NUM_PORTS]     per-port read request
//   req_wr[NUM_PORTS*BE]  per-port write byte enables (any bit set = write)
//   req_addr, req_wdata   per-port address / write data, packed by port
//   req_accept            one-hot: granted command taken by the core
//   req_ack, req_error    one-hot completion pulse / failure flag
//   req_rdata             read data, non-zero only in the ack cycle of a read
//   core_rd/wr/addr/wdata command to the core (zero outside ISSUE)
//   core_accept/ack/error/rdata  core handshake and response
//   grant_valid, grant_id current owner while in ISSUE or WAIT
module sdram_arbiter #(
   parameter int NUM_PORTS      = 3,
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             req_rd,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wr,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             req_accept,
   output logic [NUM_PORTS-1:0]             req_ack,
   output logic [NUM_PORTS-1:0]             req_error,
   output logic [DATA_WIDTH-1:0]            req_rdata,
   output logic                             core_rd,
   output logic [DATA_WIDTH/8-1:0]          core_wr,
   output logic [ADDR_WIDTH-1:0]            core_addr,
   output logic [DATA_WIDTH-1:0]            core_wdata,
   input  logic                             core_accept,
   input  logic                             core_ack,
   input  logic                             core_error,
   input  logic [DATA_WIDTH-1:0]            core_rdata,
   output logic                             grant_valid,
   output logic [1:0]                       grant_id
);

   localparam int unsigned BE = DATA_WIDTH / 8;
   localparam int unsigned NP = NUM_PORTS;
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] LAST_RST = 2'(NUM_PORTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t        state, state_nx;
   logic [1:0]    grant, grant_nx;
   logic [1:0]    last_grant, last_grant_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          is_rd, is_rd_nx;

   logic [NP-1:0]         port_req;
   logic                  g_req, g_rd;
   logic [BE-1:0]         g_wr;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_wdata;
   logic [1:0]            pick;
   logic                  found;
   int unsigned           idx;

   // Request decode and granted-port mux.
   always_comb begin
      g_req   = 1'b0;
      g_rd    = 1'b0;
      g_wr    = '0;
      g_addr  = '0;
      g_wdata = '0;
      for (int unsigned i = 0; i < NP; i++) begin
         port_req[i] = req_rd[i] | (|req_wr[i*BE +: BE]);
         if (grant == 2'(i)) begin
            g_req   = port_req[i];
            g_rd    = req_rd[i];
            g_wr    = req_wr[i*BE +: BE];
            g_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            g_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round robin: first requester at or after last_grant+1, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned k = 1; k <= NP; k++) begin
         idx = (32'(last_grant) + k) % NP;
         if (!found && port_req[idx]) begin
            found = 1'b1;
            pick  = idx[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         grant      <= '0;
         last_grant <= LAST_RST;
         cnt        <= '0;
         is_rd      <= 1'b0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         last_grant <= last_grant_nx;
         cnt        <= cnt_nx;
         is_rd      <= is_rd_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      grant_nx      = grant;
      last_grant_nx = last_grant;
      cnt_nx        = cnt;
      is_rd_nx      = is_rd;
      req_accept    = '0;
      req_ack       = '0;
      req_error     = '0;
      req_rdata     = '0;
      core_rd       = 1'b0;
      core_wr       = '0;
      core_addr     = '0;
      core_wdata    = '0;
      grant_valid   = 1'b0;
      grant_id      = '0;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               grant_nx = pick;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            grant_valid = 1'b1;
            grant_id    = grant;
            core_rd     = g_rd;
            core_wr     = g_rd ? '0 : g_wr;
            core_addr   = g_addr;
            core_wdata  = g_wdata;
            // A withdrawn request abandons the grant without touching last_grant.
            if (!g_req) begin
               state_nx = S_IDLE;
            end else if (core_accept) begin
               req_accept = NP'(1) << grant;
               cnt_nx     = '0;
               is_rd_nx   = g_rd;
               state_nx   = S_WAIT;
            end
         end
         S_WAIT: begin
            grant_valid = 1'b1;
            grant_id    = grant;
            cnt_nx      = cnt + 1'b1;
            if (core_ack) begin
               req_ack       = NP'(1) << grant;
               req_error     = core_error ? (NP'(1) << grant) : '0;
               req_rdata     = is_rd ? core_rdata : '0;
               last_grant_nx = grant;
               state_nx      = S_IDLE;
            end else if (cnt == CNT_TERM) begin
               req_ack       = NP'(1) << grant;
               req_error     = NP'(1) << grant;
               last_grant_nx = grant;
               state_nx      = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
   localparam int NP = 3, AW = 24, DW = 32, BE = 4, TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic [NP-1:0]    req_rd;
   logic [NP*BE-1:0] req_wr;
   logic [NP*AW-1:0] req_addr;
   logic [NP*DW-1:0] req_wdata;
   logic [NP-1:0]    req_accept, req_ack, req_error;
   logic [DW-1:0]    req_rdata;
   logic             core_rd;
   logic [BE-1:0]    core_wr;
   logic [AW-1:0]    core_addr;
   logic [DW-1:0]    core_wdata;
   logic             core_accept, core_ack, core_error;
   logic [DW-1:0]    core_rdata;
   logic             grant_valid;
   logic [1:0]       grant_id;

   sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_accept(req_accept), .req_ack(req_ack), .req_error(req_error),
      .req_rdata(req_rdata), .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_accept(core_accept), .core_ack(core_ack),
      .core_error(core_error), .core_rdata(core_rdata), .grant_valid(grant_valid),
      .grant_id(grant_id));

   always #5 clk = ~clk;

   logic [3*NP+DW+1+BE+AW+DW+1+2-1:0] all_out;
   assign all_out = {req_accept, req_ack, req_error, req_rdata, core_rd, core_wr, core_addr,
                     core_wdata, grant_valid, grant_id};

   typedef struct {
      logic [1:0]    port;
      logic          is_rd;
      logic [BE-1:0] wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic set_port(input int p, input logic rd, input logic [BE-1:0] wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_rd[p]            = rd;
      req_wr[p*BE +: BE]   = wr;
      req_addr[p*AW +: AW] = a;
      req_wdata[p*DW +: DW] = d;
   endtask

   task automatic push_exp(input int p, input logic rd, input logic [BE-1:0] wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] rdata, input logic err);
      exp_t e;
      e.port = 2'(p); e.is_rd = rd; e.wr = rd ? '0 : wr; e.addr = a; e.wdata = d;
      e.rdata = rd ? rdata : '0; e.err = err;
      sb.push_back(e);
   endtask

   task automatic clear_inputs();
      req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      core_accept = 1'b0; core_ack = 1'b0; core_error = 1'b0; core_rdata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Acts as the core for one transaction; compares it against the scoreboard head.
   task automatic serve(input int acc_dly, input int ack_dly, input logic [DW-1:0] rd_val,
                        input logic err_val, input bit clr);
      exp_t e;
      int w;
      n_checks++;
      if (sb.size() == 0) begin
         $display("FAIL sb_empty: got size 0, need >0");
         n_fail++;
         return;
      end
      e = sb.pop_front();
      w = 0;
      @(negedge clk); #1;
      while (!grant_valid && w < 20) begin
         @(negedge clk); #1;
         w++;
      end
      n_checks++;
      if (grant_valid !== 1'b1) begin
         $display("FAIL grant_wait: got grant_valid=%b after %0d cycles, need 1", grant_valid, w);
         n_fail++;
         return;
      end
      n_checks++;
      if (grant_id !== e.port) begin
         $display("FAIL grant_order: got %0d, need %0d", grant_id, e.port);
         n_fail++;
      end
      n_checks++;
      if ({core_rd, core_wr, core_addr, core_wdata} !== {e.is_rd, e.wr, e.addr, e.wdata}) begin
         $display("FAIL issue_cmd: got rd=%b wr=%h a=%h d=%h, need rd=%b wr=%h a=%h d=%h",
                  core_rd, core_wr, core_addr, core_wdata, e.is_rd, e.wr, e.addr, e.wdata);
         n_fail++;
      end
      repeat (acc_dly) begin
         n_checks++;
         if (req_accept !== '0) begin
            $display("FAIL early_accept: got %b, need 000", req_accept);
            n_fail++;
         end
         @(negedge clk); #1;
      end
      core_accept = 1'b1; #1;
      n_checks++;
      if (req_accept !== (NP'(1) << e.port)) begin
         $display("FAIL accept: got %b, need %b", req_accept, NP'(1) << e.port);
         n_fail++;
      end
      for (int k = 1; k <= ack_dly; k++) begin
         @(negedge clk);
         core_accept = 1'b0; #1;
         if (k < ack_dly) begin
            n_checks++;
            if ({req_ack, req_accept} !== '0) begin
               $display("FAIL wait_quiet: got ack=%b accept=%b at k=%0d, need 0", req_ack, req_accept, k);
               n_fail++;
            end
         end
      end
      core_ack = 1'b1; core_rdata = rd_val; core_error = err_val; #1;
      n_checks++;
      if ({req_ack, req_error, req_rdata} !==
          {NP'(1) << e.port, e.err ? (NP'(1) << e.port) : NP'(0), e.rdata}) begin
         $display("FAIL ack: got ack=%b err=%b rdata=%h, need ack=%b err=%b rdata=%h",
                  req_ack, req_error, req_rdata, NP'(1) << e.port, e.err, e.rdata);
         n_fail++;
      end
      if (clr) set_port(e.port, 1'b0, '0, '0, '0);
      @(negedge clk);
      core_ack = 1'b0; core_rdata = '0; core_error = 1'b0; #1;
      n_checks++;
      if (grant_valid !== 1'b0 || req_ack !== '0) begin
         $display("FAIL idle_gap: got grant_valid=%b ack=%b, need 0 0", grant_valid, req_ack);
         n_fail++;
      end
   endtask

   task automatic wait_grant(output bit ok);
      int w;
      w = 0;
      @(negedge clk); #1;
      while (!grant_valid && w < 20) begin
         @(negedge clk); #1;
         w++;
      end
      ok = grant_valid;
      n_checks++;
      if (!ok) begin
         $display("FAIL grant_wait: no grant within %0d cycles", w);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (all_out !== '0) begin
         $display("FAIL reset_outputs: got %h, need 0", all_out);
         n_fail++;
      end
      core_ack = 1'b1; core_accept = 1'b1; set_port(0, 1'b1, '0, 24'h1, '0); #1;
      n_checks++;
      if (all_out !== '0) begin
         $display("FAIL reset_inputs_active: got %h, need 0", all_out);
         n_fail++;
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
   endtask

   task automatic test_read();
      @(negedge clk);
      core_ack = 1'b1; core_rdata = 32'h1; #1;
      n_checks++;
      if (req_ack !== '0) begin
         $display("FAIL idle_ack_ignored: got %b, need 000", req_ack);
         n_fail++;
      end
      core_ack = 1'b0; core_rdata = '0;
      set_port(1, 1'b1, '0, 24'h000100, '0); #1;
      n_checks++;
      if ({grant_valid, core_rd, core_wr, core_addr} !== '0) begin
         $display("FAIL idle_cmd_zero: got gv=%b rd=%b wr=%h a=%h, need 0", grant_valid, core_rd, core_wr, core_addr);
         n_fail++;
      end
      push_exp(1, 1'b1, '0, 24'h000100, '0, 32'hDEADBEEF, 1'b0);
      serve(1, 6, 32'hDEADBEEF, 1'b0, 1'b1);
   endtask

   task automatic test_two_writes();
      apply_reset();
      set_port(0, 1'b0, 4'hF, 24'h000200, 32'hA5A5_0000);
      set_port(2, 1'b0, 4'h3, 24'h000300, 32'h0000_5A5A);
      push_exp(0, 1'b0, 4'hF, 24'h000200, 32'hA5A5_0000, '0, 1'b0);
      push_exp(2, 1'b0, 4'h3, 24'h000300, 32'h0000_5A5A, '0, 1'b0);
      serve(0, 2, 32'h1234_5678, 1'b0, 1'b1);
      serve(2, 3, 32'h9999_0000, 1'b0, 1'b1);
   endtask

   task automatic test_round_robin();
      logic [DW-1:0] rv;
      set_port(0, 1'b1, 4'hF, 24'h000010, 32'h11);
      set_port(1, 1'b0, 4'h5, 24'h000020, 32'h22);
      set_port(2, 1'b1, '0,   24'h000030, 32'h33);
      for (int n = 0; n < 6; n++) begin
         rv = 32'hC0DE_0000 + 32'(n);
         case (n % 3)
            0: push_exp(0, 1'b1, 4'hF, 24'h000010, 32'h11, rv, n == 3);
            1: push_exp(1, 1'b0, 4'h5, 24'h000020, 32'h22, rv, n == 4);
            default: push_exp(2, 1'b1, '0, 24'h000030, 32'h33, rv, 1'b0);
         endcase
         serve(n % 2, 2 + n % 3, rv, (n == 3) || (n == 4), 1'b0);
      end
      clear_inputs();
   endtask

   task automatic test_drop();
      bit ok;
      @(negedge clk);
      set_port(1, 1'b1, '0, 24'h000040, '0);
      wait_grant(ok);
      if (ok) begin
         n_checks++;
         if (grant_id !== 2'd1) begin
            $display("FAIL drop_grant: got %0d, need 1", grant_id);
            n_fail++;
         end
         core_ack = 1'b1; #1;
         n_checks++;
         if ({req_ack, req_accept} !== '0) begin
            $display("FAIL issue_ack_ignored: got ack=%b accept=%b, need 0", req_ack, req_accept);
            n_fail++;
         end
         core_ack = 1'b0;
         set_port(1, 1'b0, '0, '0, '0);
         @(negedge clk); #1;
         n_checks++;
         if ({grant_valid, req_accept, req_ack} !== '0) begin
            $display("FAIL drop_idle: got gv=%b accept=%b ack=%b, need 0", grant_valid, req_accept, req_ack);
            n_fail++;
         end
      end
      set_port(1, 1'b1, '0, 24'h000041, '0);
      set_port(2, 1'b0, 4'h1, 24'h000042, 32'h77);
      push_exp(1, 1'b1, '0, 24'h000041, '0, 32'h4141_4141, 1'b0);
      push_exp(2, 1'b0, 4'h1, 24'h000042, 32'h77, '0, 1'b0);
      serve(0, 2, 32'h4141_4141, 1'b0, 1'b1);
      serve(1, 2, 32'h4242_4242, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      bit ok;
      exp_t e;
      @(negedge clk);
      set_port(0, 1'b1, '0, 24'h000050, '0);
      push_exp(0, 1'b1, '0, 24'h000050, '0, '0, 1'b1);
      e = sb.pop_front();
      wait_grant(ok);
      if (!ok) return;
      core_accept = 1'b1; #1;
      n_checks++;
      if (req_accept !== (NP'(1) << e.port)) begin
         $display("FAIL to_accept: got %b, need %b", req_accept, NP'(1) << e.port);
         n_fail++;
      end
      for (int k = 1; k <= TO + 3; k++) begin
         @(negedge clk);
         core_accept = 1'b0;
         core_rdata  = 32'hFFFF_FFFF;
         core_ack    = (k == TO + 3);
         #1;
         n_checks++;
         if (k == TO) begin
            if ({req_ack, req_error, req_rdata} !== {NP'(1) << e.port, NP'(1) << e.port, e.rdata}) begin
               $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h at k=%0d, need ack=err=%b rdata=0",
                        req_ack, req_error, req_rdata, k, NP'(1) << e.port);
               n_fail++;
            end
            set_port(0, 1'b0, '0, '0, '0);
         end else if (req_ack !== '0) begin
            $display("FAIL timeout_quiet: got ack=%b at k=%0d, need 000", req_ack, k);
            n_fail++;
         end
      end
      @(negedge clk);
      core_ack = 1'b0; core_rdata = '0;
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      @(negedge clk);
      set_port(1, 1'b1, '0, 24'h000060, '0);
      wait_grant(ok);
      if (ok) begin
         core_accept = 1'b1;
         repeat (2) @(negedge clk);
         core_accept = 1'b0; #1;
         n_checks++;
         if (grant_valid !== 1'b1) begin
            $display("FAIL rw_in_wait: got grant_valid=%b, need 1", grant_valid);
            n_fail++;
         end
         rst = 1'b1; core_ack = 1'b1; core_accept = 1'b1; #1;
         n_checks++;
         if (all_out !== '0) begin
            $display("FAIL rw_async_zero: got %h, need 0", all_out);
            n_fail++;
         end
         @(negedge clk);
         rst = 1'b0; core_ack = 1'b0; core_accept = 1'b0;
      end
      set_port(0, 1'b0, 4'h8, 24'h000070, 32'h55);
      push_exp(0, 1'b0, 4'h8, 24'h000070, 32'h55, '0, 1'b0);
      push_exp(1, 1'b1, '0, 24'h000060, '0, 32'h6060_6060, 1'b0);
      serve(0, 2, 32'h0, 1'b0, 1'b1);
      serve(1, 2, 32'h6060_6060, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_two_writes();
      test_round_robin();
      test_drop();
      test_timeout();
      test_reset_in_wait();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Param NUM_PORTS, default 3: requester count, legal range 2..4.
REQ-002 Param ADDR_WIDTH, default 24: byte address width, same as the core command port.
REQ-003 Param DATA_WIDTH, default 32: data width (8/16/32); BE = DATA_WIDTH/8.
REQ-004 Param TIMEOUT_CYCLES, default 64: maximum cycles allowed in WAIT before the arbiter forces completion.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_rd  in  NUM_PORTS  per-port read request.
REQ-008 req_wr  in  NUM_PORTS*BE  per-port write byte enables; any bit set = write request.
REQ-009 req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address.
REQ-010 req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
REQ-011 req_accept  out  NUM_PORTS  one-hot; command taken by the core this cycle.
REQ-012 req_ack  out  NUM_PORTS  one-hot pulse; transaction complete.
REQ-013 req_error  out  NUM_PORTS  pulses with req_ack when the transaction failed.
REQ-014 req_rdata  out  DATA_WIDTH  shared read data; valid only in the req_ack cycle of a read; 0 otherwise.
REQ-015 core_rd / core_wr / core_addr / core_wdata  out  1 / BE / ADDR_WIDTH / DATA_WIDTH  command to the SDRAM core.
REQ-016 core_accept, core_ack, core_error  in  1 each; core_rdata  in  DATA_WIDTH.
REQ-017 grant_valid  out  1, plus grant_id  out  2: current owner; grant_valid is high in ISSUE and WAIT.

Function
REQ-018 Port i requests when req_rd[i] is high or req_wr[i] is nonzero; if both are present, the request is a read and core_wr is forced to 0.
REQ-019 The arbiter SHALL have three states: IDLE, ISSUE and WAIT.
REQ-020 IDLE: if any port requests, the arbiter registers grant = the first requesting port searching from (last_grant+1) mod NUM_PORTS upward, then moves to ISSUE next cycle; otherwise it stays in IDLE.
REQ-021 In IDLE, core_rd, core_wr, core_addr and core_wdata SHALL be 0.
REQ-022 ISSUE: core_rd, core_wr, core_addr and core_wdata SHALL combinationally mirror the granted port's inputs.
REQ-023 ISSUE: req_accept[grant] = core_accept; on core_accept the arbiter moves to WAIT.
REQ-024 ISSUE: if the granted port drops its request before core_accept, the arbiter returns to IDLE with no accept, and last_grant is unchanged.
REQ-025 WAIT: core command outputs SHALL be 0; a timeout counter clears on entry and increments each cycle.
REQ-026 WAIT, on core_ack: req_ack[grant] = 1 that same cycle, req_error[grant] = core_error, and req_rdata = core_rdata if the transaction is a read; then last_grant <= grant and the next state is IDLE.
REQ-027 WAIT, if the counter reaches TIMEOUT_CYCLES-1 with no core_ack: req_ack[grant] = 1 and req_error[grant] = 1, req_rdata = 0, last_grant <= grant, and the next state is IDLE.
REQ-028 If core_ack and the timeout coincide, core_ack wins and error follows core_error.
REQ-029 core_ack arriving in IDLE or ISSUE SHALL be ignored; no req_ack is generated.
REQ-030 At most one transaction is outstanding; at least one IDLE cycle separates consecutive grants.
REQ-031 Worst-case wait for a continuously requesting port is NUM_PORTS-1 transactions.
REQ-032 Timeout counter width = clog2(TIMEOUT_CYCLES); it does not wrap, because it exits at its terminal count.

Reset
REQ-033 While rst is high, the state SHALL be IDLE and last_grant = NUM_PORTS-1, so port 0 has first priority.
REQ-034 While rst is high, grant, the counter and every output SHALL be 0.
REQ-035 Reset asserted in ISSUE or WAIT aborts the transaction immediately; no req_ack is issued for it.
REQ-036 Operation resumes on the first rising clk edge after rst deasserts.

Verification
REQ-037 Port 1 reads addr 0x000100 after reset; core_accept 1 cycle after ISSUE, core_ack 6 cycles later with rdata 0xDEADBEEF -> req_accept[1] pulses once; req_ack[1] and req_rdata = 0xDEADBEEF in the same cycle; req_error = 0.
REQ-038 Ports 0 and 2 request writes in the same IDLE cycle right after reset -> port 0 granted first, port 2 second; each receives exactly one accept and one ack.
REQ-039 All 3 ports request continuously for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-040 TIMEOUT_CYCLES=16, core never acks -> req_ack[g] = req_error[g] = 1 exactly 16 cycles after the accept cycle; a late core_ack 3 cycles after that produces no req_ack.
REQ-041 Port 1 drops its request in ISSUE before core_accept -> return to IDLE, no accept or ack, and port 1 keeps its priority position.
REQ-042 rst asserted 2 cycles into WAIT -> all outputs 0 asynchronously; after release a port 0 request is granted first.
